ntt_sdf_ctrl: RTL and testbench
===============================

NTT_SDF_CTRL -- requirements
Module: ntt_sdf_ctrl

Interface
REQ-001 SHALL have parameter LOGN, default 4, meaning log2 of polynomial length N = 2**LOGN.
REQ-002 SHALL have parameter LOGQ, default 32, meaning the coefficient width.
REQ-003 SHALL have parameter PIPE_LAT, default 20, meaning clock cycles from a coefficient on pipe_in to its result on pipe_out across the full SDF stage chain; legal range >= 1.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_valid  input  1  configuration request.
REQ-007 cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-008 cfg_intt  input  1  requested mode: 1 = inverse NTT.
REQ-009 cfg_btf_gs  input  1  requested butterfly: 1 = GS, 0 = CT.
REQ-010 in_valid  input  1  input coefficient valid.
REQ-011 in_ready  output  1  controller accepts a coefficient this cycle.
REQ-012 in_data  input  LOGQ  input coefficient.
REQ-013 pipe_start  output  1  start/advance enable to every stage of the chain.
REQ-014 pipe_rst  output  1  synchronous clear to the stage chain.
REQ-015 pipe_intt, pipe_btf_gs  output  1 each  latched mode to the stage chain.
REQ-016 pipe_in  output  LOGQ  coefficient to the first stage.
REQ-017 pipe_out  input  LOGQ  result from the last stage.
REQ-018 out_valid  output  1  out_data holds a valid result; there is no backpressure.
REQ-019 out_data  output  LOGQ  result coefficient, registered.
REQ-020 done  output  1  one-cycle pulse with the last result.
REQ-021 err_underrun  output  1  sticky flag: a bubble occurred during LOAD.

Function
REQ-022 SHALL implement four states: IDLE, LOAD, FLUSH and CLEAR.
REQ-023 IDLE: cfg_ready=1, in_ready=0, pipe_start=0; on cfg_valid, latch cfg_intt and cfg_btf_gs into pipe_intt and pipe_btf_gs, clear the cycle counter, clear err_underrun, and go to LOAD.
REQ-024 LOAD: in_ready=1 and pipe_start=1 every cycle for exactly N cycles; pipe_in=in_data when in_valid=1.
- Bubble (in_valid=0): pipe_in=0, err_underrun set, counter still advances; no stall.
REQ-025 After the N-th LOAD cycle, SHALL go to FLUSH with pipe_start=1, pipe_in=0 and in_ready=0.
REQ-026 The cycle counter t SHALL start at 0 on the first LOAD cycle and increment every cycle through LOAD and FLUSH.
- Width: clog2(N+PIPE_LAT+1) bits.
- No wrap-around.
REQ-027 out_data SHALL register pipe_out; out_valid SHALL be 1 on the cycles following t = PIPE_LAT .. PIPE_LAT+N-1, giving exactly N results in order.
REQ-028 done SHALL pulse with the N-th out_valid; the state then moves to CLEAR.
REQ-029 CLEAR: pipe_rst=1 and pipe_start=0 for exactly one cycle, then IDLE.
REQ-030 pipe_intt and pipe_btf_gs SHALL NOT change outside IDLE; cfg_valid outside IDLE is ignored and cfg_ready=0.
REQ-031 in_valid outside LOAD SHALL be ignored; no coefficient is consumed.
REQ-032 Simultaneous cfg_valid and in_valid in IDLE: only cfg is accepted; in_data is not consumed that cycle.
REQ-033 If PIPE_LAT < N, output overlaps LOAD; FLUSH still runs until t reaches PIPE_LAT+N-1.

Reset
REQ-034 rst SHALL force IDLE, t=0, pipe_rst=1 that cycle, and all of the following to 0: pipe_start, in_ready, out_valid, out_data, done, err_underrun, pipe_intt, pipe_btf_gs, pipe_in.
REQ-035 rst asserted mid-LOAD or mid-FLUSH SHALL abort the polynomial.
- No done pulse.
- No further out_valid.
- cfg_ready=1 on the first cycle after rst deasserts.

Verification
REQ-036 N=16, PIPE_LAT=20, cfg (intt=0, gs=0), continuous in_data 1..16 -> pipe_start high 36 cycles; out_valid 16 cycles starting the cycle after t=20; done coincident with the 16th result; one pipe_rst cycle; cfg_ready=1 again.
REQ-037 in_valid dropped on the 5th LOAD cycle -> pipe_in=0 that cycle; err_underrun=1 and held until the next cfg accept; exactly 16 outputs still produced.
REQ-038 cfg_valid pulsed with intt=1 during FLUSH -> ignored, pipe_intt stays 0; accepted on the first IDLE cycle, and pipe_intt=1 from the next cycle.
REQ-039 rst asserted at t=10 -> out_valid, done and pipe_start are 0 from the next cycle; pipe_rst=1 during rst; next poly runs a full 16 outputs.
REQ-040 PIPE_LAT=4 with N=16 -> out_valid first seen during LOAD, exactly 16 results, done at t=19+1.
REQ-041 cfg_valid and in_valid both high in IDLE -> cfg accepted; the first consumed coefficient is the one presented on the first LOAD cycle.

Source files
------------

// File: rtl/ntt_sdf_ctrl.sv
// Sequencing controller for a single-path delay-feedback NTT stage chain.
// Loads N coefficients, flushes the pipeline, collects N results, then clears the chain.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for cfg_valid; mode bits may be latched
// S_LOAD  | N cycles feeding coefficients into the chain
// S_FLUSH | feeding zeros until the last result leaves the chain
// S_CLEAR | one-cycle synchronous clear of the stage chain
module ntt_sdf_ctrl #(
    parameter int LOGN     = 4,
    parameter int LOGQ     = 32,
    parameter int PIPE_LAT = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            cfg_intt,
    input  logic            cfg_btf_gs,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,
    output logic            pipe_start,
    output logic            pipe_rst,
    output logic            pipe_intt,
    output logic            pipe_btf_gs,
    output logic [LOGQ-1:0] pipe_in,
    input  logic [LOGQ-1:0] pipe_out,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data,
    output logic            done,
    output logic            err_underrun
);

    localparam int N  = 1 << LOGN;
    localparam int TW = $clog2(N + PIPE_LAT + 1);
    localparam logic [TW-1:0] T_LOAD_END  = TW'(N - 1);
    localparam logic [TW-1:0] T_OUT_FIRST = TW'(PIPE_LAT);
    localparam logic [TW-1:0] T_OUT_LAST  = TW'(PIPE_LAT + N - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_CLEAR} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] t;
    logic          cfg_acc;
    logic          busy;
    logic          out_win;

    assign cfg_acc = (state == S_IDLE) && cfg_valid;
    assign busy    = (state == S_LOAD) || (state == S_FLUSH);
    // Result window: pipe_out carries the j-th result at t = PIPE_LAT + j.
    assign out_win = busy && (t >= T_OUT_FIRST) && (t <= T_OUT_LAST);

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;
        pipe_start = 1'b0;
        pipe_rst   = 1'b0;
        pipe_in    = '0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready   = 1'b1;
                pipe_start = 1'b1;
                if (in_valid) pipe_in = in_data;
                if (t == T_LOAD_END) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                pipe_start = 1'b1;
                if (t == T_OUT_LAST) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                pipe_rst  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset also clears the chain during the reset cycle itself.
        if (rst) begin
            cfg_ready  = 1'b0;
            in_ready   = 1'b0;
            pipe_start = 1'b0;
            pipe_in    = '0;
            pipe_rst   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            t            <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
            pipe_intt    <= 1'b0;
            pipe_btf_gs  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= out_win;
            done      <= out_win && (t == T_OUT_LAST);
            if (out_win) out_data <= pipe_out;
            if (cfg_acc) begin
                t            <= '0;
                err_underrun <= 1'b0;
                pipe_intt    <= cfg_intt;
                pipe_btf_gs  <= cfg_btf_gs;
            end else if (busy && (t != T_OUT_LAST)) begin
                t <= t + 1'b1;
            end
            if ((state == S_LOAD) && !in_valid) err_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Randomized bench for ntt_sdf_ctrl: two instances (PIPE_LAT 20 and 4) share stimulus
// and are checked every cycle against a timeline model built from polynomial start times.
module tb_ntt_sdf_ctrl;

    localparam int N    = 16;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0, cfg_intt = 1'b0, cfg_btf_gs = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic [1:0]  cfg_ready_v, in_ready_v, pipe_start_v, pipe_rst_v;
    logic [1:0]  pipe_intt_v, pipe_btf_gs_v, out_valid_v, done_v, err_v;
    logic [31:0] pipe_in_v  [2];
    logic [31:0] pipe_out_v [2];
    logic [31:0] out_data_v [2];

    logic [31:0] ch20 [20];
    logic [31:0] ch4  [4];

    int n_chk = 0, n_fail = 0;
    int lat [2] = '{20, 4};
    bit act [2], err_m [2], intt_m [2], gs_m [2], after_rst [2];
    int st [2];
    logic [31:0] ld [2][N];
    int n_ov_dut [2], n_ov_mod [2];

    always #5 clk = ~clk;

    ntt_sdf_ctrl #(.LOGN(4), .LOGQ(32), .PIPE_LAT(20)) dut20 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_v[0]),
        .cfg_intt(cfg_intt), .cfg_btf_gs(cfg_btf_gs), .in_valid(in_valid),
        .in_ready(in_ready_v[0]), .in_data(in_data), .pipe_start(pipe_start_v[0]),
        .pipe_rst(pipe_rst_v[0]), .pipe_intt(pipe_intt_v[0]), .pipe_btf_gs(pipe_btf_gs_v[0]),
        .pipe_in(pipe_in_v[0]), .pipe_out(pipe_out_v[0]), .out_valid(out_valid_v[0]),
        .out_data(out_data_v[0]), .done(done_v[0]), .err_underrun(err_v[0]));

    ntt_sdf_ctrl #(.LOGN(4), .LOGQ(32), .PIPE_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_v[1]),
        .cfg_intt(cfg_intt), .cfg_btf_gs(cfg_btf_gs), .in_valid(in_valid),
        .in_ready(in_ready_v[1]), .in_data(in_data), .pipe_start(pipe_start_v[1]),
        .pipe_rst(pipe_rst_v[1]), .pipe_intt(pipe_intt_v[1]), .pipe_btf_gs(pipe_btf_gs_v[1]),
        .pipe_in(pipe_in_v[1]), .pipe_out(pipe_out_v[1]), .out_valid(out_valid_v[1]),
        .out_data(out_data_v[1]), .done(done_v[1]), .err_underrun(err_v[1]));

    // Stage-chain stand-ins: pure delay lines that advance on pipe_start.
    always_ff @(posedge clk) begin
        if (pipe_rst_v[0]) begin
            for (int j = 0; j < 20; j++) ch20[j] <= '0;
        end else if (pipe_start_v[0]) begin
            ch20[0] <= pipe_in_v[0];
            for (int j = 1; j < 20; j++) ch20[j] <= ch20[j-1];
        end
    end
    always_ff @(posedge clk) begin
        if (pipe_rst_v[1]) begin
            for (int j = 0; j < 4; j++) ch4[j] <= '0;
        end else if (pipe_start_v[1]) begin
            ch4[0] <= pipe_in_v[1];
            for (int j = 1; j < 4; j++) ch4[j] <= ch4[j-1];
        end
    end
    assign pipe_out_v[0] = ch20[19];
    assign pipe_out_v[1] = ch4[3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // tt = cycles since the first LOAD cycle of the current polynomial.
    task automatic model_cycle(input int i, input int k);
        int L, tt;
        bit e_load, e_start, e_prst, e_cr, e_ov, e_done;
        logic [31:0] e_pin;
        string p;
        L  = lat[i];
        tt = act[i] ? (k - st[i]) : -1;
        p  = $sformatf("L%0d ", L);
        e_load  = act[i] && (tt < N);
        e_start = act[i] && (tt < N + L);
        e_prst  = act[i] && (tt == N + L);
        e_cr    = !act[i];
        e_ov    = act[i] && (tt >= L + 1) && (tt <= L + N);
        e_done  = act[i] && (tt == L + N);
        e_pin   = (e_load && in_valid) ? in_data : 32'd0;
        if (rst) begin
            e_load = 0; e_start = 0; e_prst = 1; e_cr = 0; e_pin = '0;
        end
        check({p, "cfg_ready"},  cfg_ready_v[i],   e_cr);
        check({p, "in_ready"},   in_ready_v[i],    e_load);
        check({p, "pipe_start"}, pipe_start_v[i],  e_start);
        check({p, "pipe_rst"},   pipe_rst_v[i],    e_prst);
        check({p, "pipe_in"},    pipe_in_v[i],     e_pin);
        check({p, "out_valid"},  out_valid_v[i],   e_ov);
        check({p, "done"},       done_v[i],        e_done);
        check({p, "err"},        err_v[i],         err_m[i]);
        check({p, "pipe_intt"},  pipe_intt_v[i],   intt_m[i]);
        check({p, "pipe_gs"},    pipe_btf_gs_v[i], gs_m[i]);
        if (e_ov) check({p, "out_data"}, out_data_v[i], ld[i][tt-L-1]);
        if (after_rst[i]) check({p, "out_data rst"}, out_data_v[i], 0);
        if (out_valid_v[i] === 1'b1) n_ov_dut[i]++;
        if (e_ov) n_ov_mod[i]++;

        after_rst[i] = rst;
        if (rst) begin
            act[i] = 0; err_m[i] = 0; intt_m[i] = 0; gs_m[i] = 0;
        end else if (!act[i]) begin
            if (cfg_valid) begin
                act[i] = 1; st[i] = k + 1; err_m[i] = 0;
                intt_m[i] = cfg_intt; gs_m[i] = cfg_btf_gs;
            end
        end else begin
            if (tt < N) begin
                ld[i][tt] = in_valid ? in_data : 32'd0;
                if (!in_valid) err_m[i] = 1;
            end
            if (tt == N + L) act[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; err_m[i] = 0; intt_m[i] = 0; gs_m[i] = 0; after_rst[i] = 1;
            st[i] = 0; n_ov_dut[i] = 0; n_ov_mod[i] = 0;
        end
        repeat (2) @(posedge clk);
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            if (k < 80) begin
                // Clean poly with data 1..16, cfg and in_valid together on the accept cycle,
                // then an intt=1 request while the L20 instance is still flushing.
                rst        = 1'b0;
                cfg_valid  = (k == 1) || (k == 25);
                cfg_intt   = (k == 25);
                cfg_btf_gs = 1'b0;
                in_valid   = (k >= 1) && (k <= 17);
                in_data    = (k == 1) ? 32'hdead_beef : 32'(k - 1);
            end else begin
                rst        = ($urandom_range(0, 199) == 0);
                cfg_valid  = ($urandom_range(0, 7) == 0);
                cfg_intt   = 1'($urandom);
                cfg_btf_gs = 1'($urandom);
                in_valid   = ($urandom_range(0, 9) != 0);
                in_data    = $urandom;
            end
            #1;
            model_cycle(0, k);
            model_cycle(1, k);
        end
        check("L20 result count", n_ov_dut[0], n_ov_mod[0]);
        check("L4 result count",  n_ov_dut[1], n_ov_mod[1]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
